axi_perf_mon: RTL and testbench

AXI_PERF_MON -- requirements
Module: axi_perf_mon

---
 rtl/axi_perf_mon_if.sv | 30 +++
 rtl/axi_perf_mon.sv | 240 ++++++++++++++++++++++++
 tb/tb_axi_perf_mon.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_perf_mon_if.sv
// Snoop bundle of one AXI port: valid/ready of all five channels plus rlast and responses.
// Latency: none, plain wires.
// Backpressure: none; the slave side only observes, the master side (traffic) drives every wire.
interface axi_perf_mon_if;
    logic       arvalid;
    logic       arready;
    logic       rvalid;
    logic       rready;
    logic       rlast;
    logic [1:0] rresp;
    logic       awvalid;
    logic       awready;
    logic       wvalid;
    logic       wready;
    logic       bvalid;
    logic       bready;
    logic [1:0] bresp;

    // Traffic side: the generator/interconnect pair that actually owns these wires.
    modport master (
        output arvalid, arready, rvalid, rready, rlast, rresp,
        output awvalid, awready, wvalid, wready, bvalid, bready, bresp
    );

    // Monitor side: read-only view.
    modport slave (
        input arvalid, arready, rvalid, rready, rlast, rresp,
        input awvalid, awready, wvalid, wready, bvalid, bready, bresp
    );
endinterface

// File: rtl/axi_perf_mon.sv
// Passive AXI performance monitor: counts cycles, transactions, beats and error responses in a start/stop window.
// Latency: a handshake in cycle N shows in the registered counters/status at cycle N+1.
// Backpressure: none; never drives the bus, counters saturate instead of wrapping.
module axi_perf_mon #(
    parameter int CNT_W   = 32,
    parameter int OUTST_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    axi_perf_mon_if.slave      bus,
    output logic               busy,
    output logic               done,
    output logic               sat,
    output logic               proto_err,
    output logic [CNT_W-1:0]   cyc_cnt,
    output logic [CNT_W-1:0]   rd_txn,
    output logic [CNT_W-1:0]   wr_txn,
    output logic [CNT_W-1:0]   rd_beats,
    output logic [CNT_W-1:0]   wr_beats,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [OUTST_W-1:0] max_rd_outst
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter slots, all sharing one saturating-increment path.
    localparam int N_CNT   = 6;
    localparam int C_CYC   = 0;
    localparam int C_RDTXN = 1;
    localparam int C_WRTXN = 2;
    localparam int C_RDBT  = 3;
    localparam int C_WRBT  = 4;
    localparam int C_ERR   = 5;

    localparam logic [CNT_W+1:0]   CNT_MAX = {2'b00, {CNT_W{1'b1}}};
    localparam logic [OUTST_W-1:0] OUT_ONE = {{(OUTST_W-1){1'b0}}, 1'b1};
    localparam logic [OUTST_W-1:0] OUT_MAX = {OUTST_W{1'b1}};

    state_t state_q;
    state_t state_d;
    logic   cnt_en;
    logic   stop_req_q;

    logic ar_hs;
    logic r_hs;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic r_err;
    logic b_err;
    logic rd_close;

    assign ar_hs    = bus.arvalid & bus.arready;
    assign r_hs     = bus.rvalid  & bus.rready;
    assign aw_hs    = bus.awvalid & bus.awready;
    assign w_hs     = bus.wvalid  & bus.wready;
    assign b_hs     = bus.bvalid  & bus.bready;
    assign r_err    = r_hs & (bus.rresp != 2'b00);
    assign b_err    = b_hs & (bus.bresp != 2'b00);
    assign rd_close = r_hs & bus.rlast;

    logic [CNT_W-1:0] cnt_q   [N_CNT];
    logic [CNT_W-1:0] cnt_d   [N_CNT];
    logic [1:0]       cnt_inc [N_CNT];
    logic [CNT_W+1:0] cnt_sum [N_CNT];
    logic             cnt_ovf;

    logic [OUTST_W-1:0] rd_outst_q;
    logic [OUTST_W-1:0] rd_outst_d;
    logic [OUTST_W-1:0] wr_outst_q;
    logic [OUTST_W-1:0] wr_outst_d;
    logic [OUTST_W-1:0] max_rd_q;
    logic [OUTST_W-1:0] max_rd_d;
    logic               rd_ovf;
    logic               rd_und;
    logic               wr_ovf;
    logic               wr_und;

    // State register plus the registered busy/done decode of the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == ARMED) || (state_d == RUN);
            done    <= (state_d == DONE);
        end
    end

    // Next state and count window; start overrides everything, including a pending stop.
    always_comb begin
        state_d = state_q;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            ARMED: begin
                // The first address handshake opens the window and is itself counted.
                if (ar_hs || aw_hs) begin
                    state_d = RUN;
                    cnt_en  = 1'b1;
                end
            end
            RUN: begin
                cnt_en = 1'b1;
                // Close only once the bus is quiet: nothing in flight and no new address now.
                if (stop_req_q && (rd_outst_q == '0) && (wr_outst_q == '0) && !ar_hs && !aw_hs) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (start) begin
            state_d = ARMED;
            cnt_en  = 1'b0;
        end
    end

    // Per-counter increments and saturating sums; err can step by two in one cycle.
    always_comb begin
        cnt_inc[C_CYC]   = 2'd1;
        cnt_inc[C_RDTXN] = {1'b0, ar_hs};
        cnt_inc[C_WRTXN] = {1'b0, aw_hs};
        cnt_inc[C_RDBT]  = {1'b0, r_hs};
        cnt_inc[C_WRBT]  = {1'b0, w_hs};
        cnt_inc[C_ERR]   = {1'b0, r_err} + {1'b0, b_err};
        cnt_ovf          = 1'b0;
        for (int i = 0; i < N_CNT; i++) begin
            cnt_sum[i] = {2'b00, cnt_q[i]} + {{CNT_W{1'b0}}, cnt_inc[i]};
            if (cnt_sum[i] > CNT_MAX) begin
                cnt_d[i] = {CNT_W{1'b1}};
                cnt_ovf  = 1'b1;
            end else begin
                cnt_d[i] = cnt_sum[i][CNT_W-1:0];
            end
        end
    end

    // Read tracker and its high-water mark; a close with nothing open, or an open past full, is a protocol error.
    always_comb begin
        rd_outst_d = rd_outst_q;
        rd_ovf     = 1'b0;
        rd_und     = 1'b0;
        if (rd_close && (rd_outst_q == '0)) begin
            rd_und = 1'b1;
        end
        if (ar_hs && !rd_close) begin
            if (rd_outst_q == OUT_MAX) begin
                rd_ovf = 1'b1;
            end else begin
                rd_outst_d = rd_outst_q + OUT_ONE;
            end
        end else if (rd_close && !ar_hs && (rd_outst_q != '0)) begin
            rd_outst_d = rd_outst_q - OUT_ONE;
        end
        max_rd_d = max_rd_q;
        if (rd_ovf) begin
            max_rd_d = OUT_MAX;
        end else if (rd_outst_d > max_rd_q) begin
            max_rd_d = rd_outst_d;
        end
    end

    // Write tracker: AW opens, B closes, same rail rules as the read side.
    always_comb begin
        wr_outst_d = wr_outst_q;
        wr_ovf     = 1'b0;
        wr_und     = 1'b0;
        if (b_hs && (wr_outst_q == '0)) begin
            wr_und = 1'b1;
        end
        if (aw_hs && !b_hs) begin
            if (wr_outst_q == OUT_MAX) begin
                wr_ovf = 1'b1;
            end else begin
                wr_outst_d = wr_outst_q + OUT_ONE;
            end
        end else if (b_hs && !aw_hs && (wr_outst_q != '0)) begin
            wr_outst_d = wr_outst_q - OUT_ONE;
        end
    end

    // Measurement state: cleared by reset or start, updated only inside the count window.
    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            for (int i = 0; i < N_CNT; i++) begin
                cnt_q[i] <= '0;
            end
            rd_outst_q <= '0;
            wr_outst_q <= '0;
            max_rd_q   <= '0;
            sat        <= 1'b0;
            proto_err  <= 1'b0;
            stop_req_q <= 1'b0;
        end else begin
            if (cnt_en) begin
                for (int i = 0; i < N_CNT; i++) begin
                    cnt_q[i] <= cnt_d[i];
                end
                rd_outst_q <= rd_outst_d;
                wr_outst_q <= wr_outst_d;
                max_rd_q   <= max_rd_d;
                sat        <= sat | cnt_ovf;
                proto_err  <= proto_err | rd_ovf | rd_und | wr_ovf | wr_und;
            end
            // Stop is only meaningful while running; it is consumed when the window closes.
            if (state_q == RUN) begin
                if (state_d == DONE) begin
                    stop_req_q <= 1'b0;
                end else if (stop) begin
                    stop_req_q <= 1'b1;
                end
            end
        end
    end

    assign cyc_cnt      = cnt_q[C_CYC];
    assign rd_txn       = cnt_q[C_RDTXN];
    assign wr_txn       = cnt_q[C_WRTXN];
    assign rd_beats     = cnt_q[C_RDBT];
    assign wr_beats     = cnt_q[C_WRBT];
    assign err_cnt      = cnt_q[C_ERR];
    assign max_rd_outst = max_rd_q;

endmodule

// File: tb/tb_axi_perf_mon.sv
// Bench for axi_perf_mon: a default-width and a narrow (CNT_W=4, OUTST_W=3) monitor snoop one shared bus.
// Latency: outputs are checked 1 time unit after every rising edge against a behavioural model.
// Backpressure: none; the bench drives all bus wires directly.
module tb_axi_perf_mon;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic stop;
    always #5 clk = ~clk;

    axi_perf_mon_if bus();

    logic        b_busy, b_done, b_sat, b_perr;
    logic [31:0] b_cyc, b_rdt, b_wrt, b_rdb, b_wrb, b_err;
    logic [7:0]  b_mx;
    logic        s_busy, s_done, s_sat, s_perr;
    logic [3:0]  s_cyc, s_rdt, s_wrt, s_rdb, s_wrb, s_err;
    logic [2:0]  s_mx;

    axi_perf_mon u_big (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .bus(bus),
        .busy(b_busy), .done(b_done), .sat(b_sat), .proto_err(b_perr),
        .cyc_cnt(b_cyc), .rd_txn(b_rdt), .wr_txn(b_wrt), .rd_beats(b_rdb),
        .wr_beats(b_wrb), .err_cnt(b_err), .max_rd_outst(b_mx)
    );

    axi_perf_mon #(.CNT_W(4), .OUTST_W(3)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .bus(bus),
        .busy(s_busy), .done(s_done), .sat(s_sat), .proto_err(s_perr),
        .cyc_cnt(s_cyc), .rd_txn(s_rdt), .wr_txn(s_wrt), .rd_beats(s_rdb),
        .wr_beats(s_wrb), .err_cnt(s_err), .max_rd_outst(s_mx)
    );

    // Behavioural reference: one record per monitor instance.
    localparam int S_IDLE = 0, S_ARMED = 1, S_RUN = 2, S_DONE = 3;
    typedef struct {
        int     st;
        longint cyc, rdt, wrt, rdb, wrb, err;
        int     rdo, wro, mx;
        bit     sat, perr, sreq;
    } mdl_t;
    mdl_t m [2];

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint cmax(input int k);
        return (k == 0) ? 64'd4294967295 : 64'd15;
    endfunction

    function automatic int omax(input int k);
        return (k == 0) ? 255 : 7;
    endfunction

    function automatic longint bump(input int k, input longint v, input int inc);
        if (v + inc > cmax(k)) begin
            m[k].sat = 1'b1;
            return cmax(k);
        end
        return v + inc;
    endfunction

    // Apply one clock edge of the rules to both model records, using the inputs present at that edge.
    task automatic model_step();
        bit ar, aw, r, w, b, rl, act, go_done;
        ar = bus.arvalid && bus.arready;
        aw = bus.awvalid && bus.awready;
        r  = bus.rvalid && bus.rready;
        w  = bus.wvalid && bus.wready;
        b  = bus.bvalid && bus.bready;
        rl = r && bus.rlast;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m[k] = '{default: 0};
            end else if (start) begin
                m[k] = '{default: 0};
                m[k].st = S_ARMED;
            end else begin
                act     = (m[k].st == S_RUN) || (m[k].st == S_ARMED && (ar || aw));
                go_done = (m[k].st == S_RUN) && m[k].sreq && m[k].rdo == 0 && m[k].wro == 0 && !ar && !aw;
                if (m[k].st == S_RUN && stop) m[k].sreq = 1'b1;
                if (act) begin
                    m[k].cyc = bump(k, m[k].cyc, 1);
                    m[k].rdt = bump(k, m[k].rdt, int'(ar));
                    m[k].wrt = bump(k, m[k].wrt, int'(aw));
                    m[k].rdb = bump(k, m[k].rdb, int'(r));
                    m[k].wrb = bump(k, m[k].wrb, int'(w));
                    m[k].err = bump(k, m[k].err, int'(r && bus.rresp != 2'd0) + int'(b && bus.bresp != 2'd0));
                    if (rl && m[k].rdo == 0) m[k].perr = 1'b1;
                    if (ar && !rl) begin
                        if (m[k].rdo == omax(k)) begin
                            m[k].perr = 1'b1;
                            m[k].mx   = omax(k);
                        end else begin
                            m[k].rdo++;
                        end
                    end else if (rl && !ar && m[k].rdo > 0) begin
                        m[k].rdo--;
                    end
                    if (m[k].rdo > m[k].mx) m[k].mx = m[k].rdo;
                    if (b && m[k].wro == 0) m[k].perr = 1'b1;
                    if (aw && !b) begin
                        if (m[k].wro == omax(k)) m[k].perr = 1'b1;
                        else m[k].wro++;
                    end else if (b && !aw && m[k].wro > 0) begin
                        m[k].wro--;
                    end
                end
                if (m[k].st == S_ARMED && (ar || aw)) begin
                    m[k].st = S_RUN;
                end else if (go_done) begin
                    m[k].st   = S_DONE;
                    m[k].sreq = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk_eq("big.busy",  64'(b_busy), 64'(m[0].st == S_ARMED || m[0].st == S_RUN));
        chk_eq("big.done",  64'(b_done), 64'(m[0].st == S_DONE));
        chk_eq("big.sat",   64'(b_sat),  64'(m[0].sat));
        chk_eq("big.perr",  64'(b_perr), 64'(m[0].perr));
        chk_eq("big.cyc",   64'(b_cyc),  64'(m[0].cyc));
        chk_eq("big.rdtxn", 64'(b_rdt),  64'(m[0].rdt));
        chk_eq("big.wrtxn", 64'(b_wrt),  64'(m[0].wrt));
        chk_eq("big.rdbt",  64'(b_rdb),  64'(m[0].rdb));
        chk_eq("big.wrbt",  64'(b_wrb),  64'(m[0].wrb));
        chk_eq("big.err",   64'(b_err),  64'(m[0].err));
        chk_eq("big.maxrd", 64'(b_mx),   64'(m[0].mx));
        chk_eq("sml.busy",  64'(s_busy), 64'(m[1].st == S_ARMED || m[1].st == S_RUN));
        chk_eq("sml.done",  64'(s_done), 64'(m[1].st == S_DONE));
        chk_eq("sml.sat",   64'(s_sat),  64'(m[1].sat));
        chk_eq("sml.perr",  64'(s_perr), 64'(m[1].perr));
        chk_eq("sml.cyc",   64'(s_cyc),  64'(m[1].cyc));
        chk_eq("sml.rdtxn", 64'(s_rdt),  64'(m[1].rdt));
        chk_eq("sml.wrtxn", 64'(s_wrt),  64'(m[1].wrt));
        chk_eq("sml.rdbt",  64'(s_rdb),  64'(m[1].rdb));
        chk_eq("sml.wrbt",  64'(s_wrb),  64'(m[1].wrb));
        chk_eq("sml.err",   64'(s_err),  64'(m[1].err));
        chk_eq("sml.maxrd", 64'(s_mx),   64'(m[1].mx));
    endtask

    // One clock: the edge consumes the current inputs, then outputs are compared just after it.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_bus();
        bus.arvalid = 1'b0; bus.arready = 1'b0;
        bus.rvalid  = 1'b0; bus.rready  = 1'b0; bus.rlast = 1'b0; bus.rresp = 2'd0;
        bus.awvalid = 1'b0; bus.awready = 1'b0;
        bus.wvalid  = 1'b0; bus.wready  = 1'b0;
        bus.bvalid  = 1'b0; bus.bready  = 1'b0; bus.bresp = 2'd0;
    endtask

    task automatic do_start();
        idle_bus();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic ar_cycle();
        idle_bus();
        bus.arvalid = 1'b1; bus.arready = 1'b1;
        step();
        idle_bus();
    endtask

    task automatic r_cycle(input bit last, input logic [1:0] resp);
        idle_bus();
        bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = last; bus.rresp = resp;
        step();
        idle_bus();
    endtask

    task automatic stop_cycle();
        idle_bus();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic rand_bus(input bit allow_addr, input bit drain);
        bus.arvalid = allow_addr && ($urandom_range(3) == 0);
        bus.arready = ($urandom_range(1) == 0);
        bus.rvalid  = ($urandom_range(2) == 0);
        bus.rready  = ($urandom_range(3) != 0);
        bus.rlast   = drain ? ($urandom_range(1) == 0) : ($urandom_range(2) == 0);
        bus.rresp   = ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'd0;
        bus.awvalid = allow_addr && ($urandom_range(4) == 0);
        bus.awready = ($urandom_range(1) == 0);
        bus.wvalid  = ($urandom_range(1) == 0);
        bus.wready  = ($urandom_range(3) != 0);
        bus.bvalid  = ($urandom_range(3) == 0);
        bus.bready  = ($urandom_range(2) != 0);
        bus.bresp   = ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'd0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        idle_bus();
        step();
        step();
        chk_eq("rst.busy", 64'(b_busy), 64'd0);
        chk_eq("rst.done", 64'(b_done), 64'd0);
        chk_eq("rst.cyc",  64'(b_cyc),  64'd0);
        rst_n = 1'b1;
        step();

        // Single 4-beat read, stop after the data: ten counted cycles.
        do_start();
        step();
        ar_cycle();
        step();
        step();
        for (int i = 5; i <= 8; i++) r_cycle(i == 8, 2'd0);
        step();
        stop_cycle();
        step();
        chk_eq("rd1.done",  64'(b_done), 64'd1);
        chk_eq("rd1.cyc",   64'(b_cyc),  64'd10);
        chk_eq("rd1.rdtxn", 64'(b_rdt),  64'd1);
        chk_eq("rd1.rdbt",  64'(b_rdb),  64'd4);
        chk_eq("rd1.maxrd", 64'(b_mx),   64'd1);
        chk_eq("rd1.err",   64'(b_err),  64'd0);

        // Three reads in flight; stop arrives before the last response.
        do_start();
        step();
        for (int i = 0; i < 3; i++) ar_cycle();
        step();
        r_cycle(1'b1, 2'd0);
        r_cycle(1'b1, 2'd0);
        stop_cycle();
        r_cycle(1'b1, 2'd0);
        chk_eq("rd3.early_done", 64'(b_done), 64'd0);
        step();
        chk_eq("rd3.done",  64'(b_done), 64'd1);
        chk_eq("rd3.maxrd", 64'(b_mx),   64'd3);

        // Write with an error response alongside an unsolicited error read beat.
        do_start();
        step();
        bus.awvalid = 1'b1; bus.awready = 1'b1;
        step();
        idle_bus();
        for (int i = 0; i < 2; i++) begin
            bus.wvalid = 1'b1; bus.wready = 1'b1;
            step();
            idle_bus();
        end
        bus.bvalid = 1'b1; bus.bready = 1'b1; bus.bresp = 2'd2;
        bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1; bus.rresp = 2'd2;
        step();
        idle_bus();
        chk_eq("err.err",   64'(b_err),  64'd2);
        chk_eq("err.wrtxn", 64'(b_wrt),  64'd1);
        chk_eq("err.wrbt",  64'(b_wrb),  64'd2);
        chk_eq("err.perr",  64'(b_perr), 64'd1);

        // Twenty write beats after one AW: the 4-bit instance pins at 15 and flags saturation.
        do_start();
        step();
        bus.awvalid = 1'b1; bus.awready = 1'b1;
        step();
        idle_bus();
        for (int i = 0; i < 20; i++) begin
            bus.wvalid = 1'b1; bus.wready = 1'b1;
            step();
        end
        idle_bus();
        chk_eq("sat.s_wrbt",  64'(s_wrb), 64'd15);
        chk_eq("sat.s_sat",   64'(s_sat), 64'd1);
        chk_eq("sat.s_wrtxn", 64'(s_wrt), 64'd1);
        chk_eq("sat.s_rdtxn", 64'(s_rdt), 64'd0);
        chk_eq("sat.b_wrbt",  64'(b_wrb), 64'd20);
        chk_eq("sat.b_sat",   64'(b_sat), 64'd0);

        // Reset while two reads are open, then a clean re-arm.
        do_start();
        step();
        ar_cycle();
        ar_cycle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_eq("rmid.busy",  64'(b_busy), 64'd0);
        chk_eq("rmid.done",  64'(b_done), 64'd0);
        chk_eq("rmid.cyc",   64'(b_cyc),  64'd0);
        chk_eq("rmid.rdtxn", 64'(b_rdt),  64'd0);
        do_start();
        step();
        ar_cycle();
        r_cycle(1'b1, 2'd0);
        stop_cycle();
        step();
        chk_eq("rearm.done",  64'(b_done), 64'd1);
        chk_eq("rearm.rdtxn", 64'(b_rdt),  64'd1);
        chk_eq("rearm.perr",  64'(b_perr), 64'd0);

        // Start and stop together while running: start wins and the stop is forgotten.
        do_start();
        step();
        ar_cycle();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk_eq("ss.busy",  64'(b_busy), 64'd1);
        chk_eq("ss.cyc",   64'(b_cyc),  64'd0);
        ar_cycle();
        r_cycle(1'b1, 2'd0);
        step();
        step();
        chk_eq("ss.nodone", 64'(b_done), 64'd0);
        stop_cycle();
        step();
        chk_eq("ss.done", 64'(b_done), 64'd1);

        // Random episodes with occasional restarts and resets.
        for (int ep = 0; ep < 14; ep++) begin
            do_start();
            n = 100 + int'($urandom_range(150));
            for (int c = 0; c < n; c++) begin
                rand_bus(1'b1, 1'b0);
                stop  = ($urandom_range(39) == 0);
                start = ($urandom_range(299) == 0);
                rst_n = !($urandom_range(399) == 0);
                step();
                stop  = 1'b0;
                start = 1'b0;
                rst_n = 1'b1;
            end
            rand_bus(1'b1, 1'b0);
            stop = 1'b1;
            step();
            stop = 1'b0;
            for (int c = 0; c < 150; c++) begin
                rand_bus(1'b0, 1'b1);
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
